dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 47 ++++
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - two-master data-memory bus bundle for dmem_arbiter
interface dmem_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [3:0]  m0_be;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_lock;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;

    logic        m1_req;
    logic        m1_we;
    logic [3:0]  m1_be;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_lock;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;

    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    // Requesters plus the memory model sit on the master side.
    modport master (
        output m0_req, m0_we, m0_be, m0_addr, m0_wdata, m0_lock,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_be, m1_addr, m1_wdata, m1_lock,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_we, mem_be, mem_a, mem_wd,
        output mem_rd
    );

    modport slave (
        input  m0_req, m0_we, m0_be, m0_addr, m0_wdata, m0_lock,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_be, m1_addr, m1_wdata, m1_lock,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_we, mem_be, mem_a, mem_wd,
        input  mem_rd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data-memory arbiter, master 0 = load/store, master 1 = loader/DMA
// Optional DMEM_ARB_RR_EN: alternate the winner of simultaneous requests from IDLE.
module dmem_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN0 = 2'd1;
    localparam logic [1:0] S_OWN1 = 2'd2;
    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    logic [1:0]  state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic        rvalid0_q, rvalid1_q;
    logic [31:0] rdata0_q, rdata1_q;
    logic        gnt0_d, gnt1_d;
    logic        gnt0, gnt1;
    logic        same_owner;
    logic        contested;
    logic [7:0]  hold_base;

`ifdef DMEM_ARB_RR_EN
    logic last_owner_q;
`endif

    always_comb begin
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
        case (state_q)
            S_OWN0: begin
                if (bus.m0_req && (bus.m0_lock || !bus.m1_req) && (hold_q < HOLD_MAX))
                    gnt0_d = 1'b1;
                else if (bus.m1_req)
                    gnt1_d = 1'b1;
                else if (bus.m0_req)
                    gnt0_d = 1'b1;
            end
            S_OWN1: begin
                if (bus.m1_req && (bus.m1_lock || !bus.m0_req) && (hold_q < HOLD_MAX))
                    gnt1_d = 1'b1;
                else if (bus.m0_req)
                    gnt0_d = 1'b1;
                else if (bus.m1_req)
                    gnt1_d = 1'b1;
            end
            default: begin
                if (bus.m0_req && bus.m1_req) begin
`ifdef DMEM_ARB_RR_EN
                    if (last_owner_q)
                        gnt0_d = 1'b1;
                    else
                        gnt1_d = 1'b1;
`else
                    gnt0_d = 1'b1;
`endif
                end else if (bus.m0_req) begin
                    gnt0_d = 1'b1;
                end else if (bus.m1_req) begin
                    gnt1_d = 1'b1;
                end
            end
        endcase
    end

    // Reset blocks every grant so nothing reaches memory while rst_n is low.
    assign gnt0 = rst_n & gnt0_d;
    assign gnt1 = rst_n & gnt1_d;

    always_comb begin
        state_d = S_IDLE;
        if (gnt0_d)
            state_d = S_OWN0;
        else if (gnt1_d)
            state_d = S_OWN1;
    end

    // The grant that opens a tenure already counts toward the hold limit.
    assign same_owner = (gnt0_d && state_q == S_OWN0) || (gnt1_d && state_q == S_OWN1);
    assign contested  = gnt0_d ? bus.m1_req : (gnt1_d ? bus.m0_req : 1'b0);
    assign hold_base  = same_owner ? hold_q : 8'd0;

    always_comb begin
        hold_d = hold_base;
        if (contested && (hold_base < HOLD_MAX))
            hold_d = hold_base + 8'd1;
    end

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.mem_we    = (gnt0 & bus.m0_we) | (gnt1 & bus.m1_we);
    assign bus.mem_be    = gnt1 ? bus.m1_be    : bus.m0_be;
    assign bus.mem_a     = gnt1 ? bus.m1_addr  : bus.m0_addr;
    assign bus.mem_wd    = gnt1 ? bus.m1_wdata : bus.m0_wdata;
    assign bus.m0_rvalid = rvalid0_q;
    assign bus.m1_rvalid = rvalid1_q;
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_rdata  = rdata1_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            hold_q    <= 8'd0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= 32'd0;
            rdata1_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            rvalid0_q <= gnt0 & ~bus.m0_we;
            rvalid1_q <= gnt1 & ~bus.m1_we;
            if (gnt0 && !bus.m0_we)
                rdata0_q <= bus.mem_rd;
            if (gnt1 && !bus.m1_we)
                rdata1_q <= bus.mem_rd;
        end
    end

`ifdef DMEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            last_owner_q <= 1'b1;
        else if (gnt0)
            last_owner_q <= 1'b0;
        else if (gnt1)
            last_owner_q <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed and random checks of dmem_arbiter against a reference model
module tb_dmem_arbiter;
    localparam int MH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_arbiter_if bus();

    dmem_arbiter #(.MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] pat(input int i);
        return (32'(i) * 32'h0001_0203) ^ 32'hA5A5_0000;
    endfunction

    // Environment memory: reloaded while in reset, written by the DUT's memory port.
    logic [31:0] env_mem [64];
    assign bus.mem_rd = env_mem[bus.mem_a[7:2]];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) env_mem[i] <= pat(i);
        end else if (bus.mem_we) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_be[b]) env_mem[bus.mem_a[7:2]][8*b +: 8] <= bus.mem_wd[8*b +: 8];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [64];
    int          owner = -1;
    int          streak = 0;
    int          last = 1;
    bit          ev0 = 0, ev1 = 0;
    logic [31:0] ed0 = 0, ed1 = 0;
    bit          g0s = 0, g1s = 0;

    logic        o_g0, o_g1, o_rv0, o_rv1;
    logic [31:0] o_rd0, o_rd1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int predict();
        bit [1:0] rq;
        bit [1:0] lk;
        int x;
        if (rst_n !== 1'b1) return -1;
        rq = {bus.m1_req, bus.m0_req};
        lk = {bus.m1_lock, bus.m0_lock};
        if (owner < 0) begin
            if (rq == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
                return (last == 1) ? 0 : 1;
`else
                return 0;
`endif
            end
            if (rq[0]) return 0;
            if (rq[1]) return 1;
            return -1;
        end
        x = 1 - owner;
        if (rq[owner] && (lk[owner] || !rq[x]) && streak < MH) return owner;
        if (rq[x]) return x;
        if (rq[owner]) return owner;
        return -1;
    endfunction

    task automatic cycle();
        int          g;
        bit [1:0]    rq;
        logic        we;
        logic [3:0]  be;
        logic [31:0] a, wd, rd;
        @(negedge clk);
        g  = predict();
        rq = {bus.m1_req, bus.m0_req};
        we = (g == 1) ? bus.m1_we    : bus.m0_we;
        be = (g == 1) ? bus.m1_be    : bus.m0_be;
        a  = (g == 1) ? bus.m1_addr  : bus.m0_addr;
        wd = (g == 1) ? bus.m1_wdata : bus.m0_wdata;
        chk("m0_gnt", bus.m0_gnt, 32'(g == 0));
        chk("m1_gnt", bus.m1_gnt, 32'(g == 1));
        chk("mem_we", bus.mem_we, 32'((g >= 0) && we));
        chk("mem_a", bus.mem_a, a);
        chk("mem_be", bus.mem_be, be);
        chk("mem_wd", bus.mem_wd, wd);
        chk("m0_rvalid", bus.m0_rvalid, 32'(ev0));
        chk("m1_rvalid", bus.m1_rvalid, 32'(ev1));
        chk("m0_rdata", bus.m0_rdata, ed0);
        chk("m1_rdata", bus.m1_rdata, ed1);
        o_g0 = bus.m0_gnt;  o_g1 = bus.m1_gnt;
        o_rv0 = bus.m0_rvalid; o_rv1 = bus.m1_rvalid;
        o_rd0 = bus.m0_rdata;  o_rd1 = bus.m1_rdata;
        g0s = (g == 0);
        g1s = (g == 1);
        @(posedge clk);
        if (rst_n !== 1'b1) begin
            owner = -1; streak = 0; last = 1;
            ev0 = 0; ev1 = 0; ed0 = 0; ed1 = 0;
            for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
        end else begin
            ev0 = 0; ev1 = 0;
            if (g >= 0 && !we) begin
                rd = ref_mem[a[7:2]];
                if (g == 0) begin ev0 = 1; ed0 = rd; end
                else        begin ev1 = 1; ed1 = rd; end
            end
            if (g >= 0 && we)
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[a[7:2]][8*b +: 8] = wd[8*b +: 8];
            if (g < 0) begin
                owner = -1; streak = 0;
            end else begin
                if (g != owner) begin owner = g; streak = 0; end
                if (rq[1-g]) streak = (streak < MH) ? streak + 1 : MH;
                last = g;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_be = 4'hF; bus.m0_addr = 0; bus.m0_wdata = 0; bus.m0_lock = 0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_be = 4'hF; bus.m1_addr = 0; bus.m1_wdata = 0; bus.m1_lock = 0;
    endtask

    task automatic drive_rand();
        if (!(bus.m0_req && !g0s)) begin
            bus.m0_req   = ($urandom_range(3) != 0);
            bus.m0_we    = $urandom_range(1);
            bus.m0_be    = 4'($urandom);
            bus.m0_addr  = {24'h0, 6'($urandom), 2'b00};
            bus.m0_wdata = $urandom;
            bus.m0_lock  = ($urandom_range(2) == 0);
        end
        if (!(bus.m1_req && !g1s)) begin
            bus.m1_req   = ($urandom_range(2) != 0);
            bus.m1_we    = $urandom_range(1);
            bus.m1_be    = 4'($urandom);
            bus.m1_addr  = {24'h0, 6'($urandom), 2'b00};
            bus.m1_wdata = $urandom;
            bus.m1_lock  = ($urandom_range(1) == 0);
        end
        rst_n = ($urandom_range(79) != 0);
    endtask

    initial begin
        idle_inputs();
        // Requests held high during reset must not be granted.
        rst_n = 0;
        bus.m0_req = 1; bus.m1_req = 1; bus.m1_we = 1;
        cycle();
        cycle();
        idle_inputs();
        rst_n = 1;
        cycle();
        chk("reset_m0_rdata", o_rd0, 32'h0);
        chk("reset_m1_rvalid", o_rv1, 32'h0);

        // m1 byte-enabled write, then m0 reads it back
        bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 32'h10; bus.m1_be = 4'b0011; bus.m1_wdata = 32'h1234_5678;
        cycle();
        chk("wr_m1_gnt", o_g1, 32'h1);
        bus.m1_req = 0; bus.m1_we = 0;
        bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h10;
        cycle();
        chk("rd_m0_gnt", o_g0, 32'h1);
        bus.m0_req = 0;
        cycle();
        chk("rd_m0_rvalid", o_rv0, 32'h1);
        chk("rd_m0_rdata_lo", o_rd0 & 32'hFFFF, 32'h5678);

        // simultaneous reads from IDLE
        cycle();
        bus.m0_req = 1; bus.m0_addr = 32'h20; bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 32'h24;
        cycle();
`ifdef DMEM_ARB_RR_EN
        chk("tie_first_m1", o_g1, 32'h1);
`else
        chk("tie_first_m0", o_g0, 32'h1);
`endif
        if (g0s) bus.m0_req = 0; else bus.m1_req = 0;
        cycle();
        bus.m0_req = 0; bus.m1_req = 0;
        cycle();
        cycle();

        // hold limit overrides lock
        bus.m0_req = 1; bus.m0_lock = 1; bus.m0_we = 0; bus.m0_addr = 32'h0;
        cycle();
        bus.m1_req = 1; bus.m1_we = 1; bus.m1_be = 4'hF; bus.m1_addr = 32'h30; bus.m1_wdata = 32'hCAFE_F00D;
        for (int k = 0; k < 5; k++) begin
            bus.m0_addr = 32'(k * 4);
            cycle();
            if (k < 4) chk("hold_m0_gnt", o_g0, 32'h1);
            else       chk("hold_m1_gnt", o_g1, 32'h1);
        end
        idle_inputs();
        cycle();
        cycle();

        // three back-to-back reads
        for (int i = 0; i < 4; i++) begin
            bus.m0_req = (i < 3); bus.m0_we = 0; bus.m0_addr = 32'(i * 4);
            cycle();
            if (i >= 1) chk("b2b_rvalid", o_rv0, 32'h1);
        end
        cycle();

        // reset right after an m1 read grant
        bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 32'h14;
        cycle();
        bus.m1_req = 0;
        rst_n = 0;
        cycle();
        rst_n = 1;
        cycle();
        chk("rst_m1_rvalid", o_rv1, 32'h0);
        chk("rst_m1_rdata", o_rd1, 32'h0);
        bus.m1_req = 1;
        cycle();
        chk("rst_idle_m1_gnt", o_g1, 32'h1);
        bus.m1_req = 0;

        // quiet bus
        for (int i = 0; i < 5; i++) cycle();

        for (int n = 0; n < 600; n++) begin
            drive_rand();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
